// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and
// saturating stall/flush event counters.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_wen,
   input  logic              id_alusrc,
   input  logic              id_regdst,
   input  logic              id_branch,
   input  logic              id_memwrite,
   input  logic              id_memread,
   input  logic              id_memtoreg,
   input  logic [2:0]        id_aluop,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_wen,
   output logic              ex_alusrc,
   output logic              ex_branch,
   output logic              ex_memwrite,
   output logic              ex_memread,
   output logic              ex_memtoreg,
   output logic [2:0]        ex_aluop,
   output logic [DATA_W-1:0] ex_rdata1,
   output logic [DATA_W-1:0] ex_rdata2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [RA_W-1:0]   ex_rs,
   output logic [RA_W-1:0]   ex_rt,
   output logic [RA_W-1:0]   ex_dst,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic uses_rt;
   logic hazard;
   logic bubble;

   // Hazard detection against the load currently sitting in EX
   always_comb begin
      uses_rt = 1'b0;
      hazard  = 1'b0;
      uses_rt = !id_alusrc || id_memwrite || id_branch;
      hazard  = ex_valid && ex_memread && (ex_dst != '0) &&
                ((ex_dst == id_rs) || ((ex_dst == id_rt) && uses_rt)) &&
                id_valid;
   end

   // Flush overrides the stall; the bubble it loads also resolves the hazard
   assign stall  = hazard && !flush;
   assign bubble = flush || hazard || !id_valid;

   // Pipeline register: captures every edge, either the decode slot or a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_wen      <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_branch   <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_aluop    <= '0;
         ex_rdata1   <= '0;
         ex_rdata2   <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_dst      <= '0;
      end else if (bubble) begin
         ex_valid    <= 1'b0;
         ex_wen      <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_branch   <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_aluop    <= '0;
         ex_rdata1   <= '0;
         ex_rdata2   <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_dst      <= '0;
      end else begin
         ex_valid    <= 1'b1;
         ex_wen      <= id_wen;
         ex_alusrc   <= id_alusrc;
         ex_branch   <= id_branch;
         ex_memwrite <= id_memwrite;
         ex_memread  <= id_memread;
         ex_memtoreg <= id_memtoreg;
         ex_aluop    <= id_aluop;
         ex_rdata1   <= id_rdata1;
         ex_rdata2   <= id_rdata2;
         ex_imm      <= id_imm;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_dst      <= id_regdst ? id_rd : id_rt;
      end
   end

   // Saturating event counters for stalls and squashed valid instructions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush && id_valid && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are pushed when an
// instruction is issued and popped after the capturing edge.
module tb_id_ex_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RA_W   = 5;
   localparam int unsigned CNT_W  = 8;

   typedef struct packed {
      logic        valid, wen, alusrc, regdst, branch, memwrite, memread, memtoreg;
      logic [2:0]  aluop;
      logic [31:0] r1, r2, imm;
      logic [4:0]  rs, rt, rd;
   } instr_t;

   typedef struct packed {
      logic        valid, wen, alusrc, branch, memwrite, memread, memtoreg;
      logic [2:0]  aluop;
      logic [31:0] r1, r2, imm;
      logic [4:0]  rs, rt, dst;
   } ex_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic id_valid = 0, id_wen = 0, id_alusrc = 0, id_regdst = 0, id_branch = 0;
   logic id_memwrite = 0, id_memread = 0, id_memtoreg = 0;
   logic [2:0] id_aluop = '0;
   logic [DATA_W-1:0] id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
   logic [RA_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic flush = 1'b0;
   logic ex_valid, ex_wen, ex_alusrc, ex_branch, ex_memwrite, ex_memread, ex_memtoreg;
   logic [2:0] ex_aluop;
   logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm;
   logic [RA_W-1:0] ex_rs, ex_rt, ex_dst;
   logic stall;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   ex_t sb[$];
   ex_t m_ex = '0;
   logic [CNT_W-1:0] m_sc = '0, m_fc = '0;
   logic exp_stall, seen_stall;

   id_ex_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_wen(id_wen),
      .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_branch(id_branch),
      .id_memwrite(id_memwrite), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
      .id_aluop(id_aluop), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_alusrc(ex_alusrc),
      .ex_branch(ex_branch), .ex_memwrite(ex_memwrite), .ex_memread(ex_memread),
      .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop), .ex_rdata1(ex_rdata1),
      .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_dst(ex_dst), .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always terminates
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout errors=%0d", errors);
      $fatal(1, "timeout");
   end

   function automatic ex_t got_ex();
      ex_t g;
      g = {ex_valid, ex_wen, ex_alusrc, ex_branch, ex_memwrite, ex_memread, ex_memtoreg,
           ex_aluop, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_dst};
      return g;
   endfunction

   function automatic instr_t mk_add(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
      instr_t i;
      i = '0;
      i.valid = 1; i.wen = 1; i.regdst = 1; i.aluop = 3'd2;
      i.r1 = 32'h1111_0000 + 32'(rs); i.r2 = 32'h2222_0000 + 32'(rt); i.imm = 32'h0000_00a5;
      i.rs = rs; i.rt = rt; i.rd = rd;
      return i;
   endfunction

   function automatic instr_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i;
      i = '0;
      i.valid = 1; i.wen = 1; i.alusrc = 1; i.memread = 1; i.memtoreg = 1; i.aluop = 3'd0;
      i.r1 = 32'hdead_0000 + 32'(rs); i.r2 = 32'hbeef_0000; i.imm = 32'hffff_fff8;
      i.rs = rs; i.rt = rt; i.rd = 5'd17;
      return i;
   endfunction

   function automatic instr_t mk_addi(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i;
      i = '0;
      i.valid = 1; i.wen = 1; i.alusrc = 1; i.aluop = 3'd2;
      i.r1 = 32'h3333_0000; i.r2 = 32'h4444_0000; i.imm = 32'h0000_0010;
      i.rs = rs; i.rt = rt; i.rd = 5'd9;
      return i;
   endfunction

   // Drive one decode slot, predict stall and EX contents, step one clock
   task automatic issue(input instr_t ins, input logic fl);
      ex_t e;
      logic ut, hz;
      @(negedge clk);
      id_valid = ins.valid; id_wen = ins.wen; id_alusrc = ins.alusrc;
      id_regdst = ins.regdst; id_branch = ins.branch; id_memwrite = ins.memwrite;
      id_memread = ins.memread; id_memtoreg = ins.memtoreg; id_aluop = ins.aluop;
      id_rdata1 = ins.r1; id_rdata2 = ins.r2; id_imm = ins.imm;
      id_rs = ins.rs; id_rt = ins.rt; id_rd = ins.rd; flush = fl;
      ut = !ins.alusrc || ins.memwrite || ins.branch;
      hz = m_ex.valid && m_ex.memread && (m_ex.dst != 5'd0) &&
           ((m_ex.dst == ins.rs) || ((m_ex.dst == ins.rt) && ut)) && ins.valid;
      exp_stall = hz && !fl;
      #1 seen_stall = stall;
      e = '0;
      if (!(fl || hz || !ins.valid)) begin
         e.valid = 1; e.wen = ins.wen; e.alusrc = ins.alusrc; e.branch = ins.branch;
         e.memwrite = ins.memwrite; e.memread = ins.memread; e.memtoreg = ins.memtoreg;
         e.aluop = ins.aluop; e.r1 = ins.r1; e.r2 = ins.r2; e.imm = ins.imm;
         e.rs = ins.rs; e.rt = ins.rt; e.dst = ins.regdst ? ins.rd : ins.rt;
      end
      sb.push_back(e);
      if (exp_stall && (m_sc != '1)) m_sc = m_sc + CNT_W'(1);
      if (fl && ins.valid && (m_fc != '1)) m_fc = m_fc + CNT_W'(1);
      m_ex = e;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (got_ex() !== ex_t'(0)) begin
         errors++; $display("FAIL reset_ex got %h exp 0", got_ex());
      end
      checks++;
      if ({stall, stall_cnt, flush_cnt} !== '0) begin
         errors++; $display("FAIL reset_cnt got stall=%b sc=%h fc=%h exp 0", stall, stall_cnt, flush_cnt);
      end
      // Inputs that would be a valid instruction are ignored while held in reset
      id_valid = 1; id_wen = 1; id_rd = 5'd7; id_regdst = 1;
      @(posedge clk); #1;
      checks++;
      if ((ex_valid !== 1'b0) || (stall !== 1'b0)) begin
         errors++; $display("FAIL reset_hold got valid=%b stall=%b exp 0 0", ex_valid, stall);
      end
      @(negedge clk);
      id_valid = 0;
      rst = 0;
   endtask

   task automatic test_add();
      ex_t e;
      issue(mk_add(5'd1, 5'd2, 5'd3), 1'b0);
      e = sb.pop_front();
      checks++;
      if (seen_stall !== 1'b0) begin
         errors++; $display("FAIL add_stall got %b exp 0", seen_stall);
      end
      checks++;
      if (got_ex() !== e) begin
         errors++; $display("FAIL add_ex got %h exp %h", got_ex(), e);
      end
      checks++;
      if ((ex_dst !== 5'd3) || (ex_valid !== 1'b1)) begin
         errors++; $display("FAIL add_dst got %0d valid %b exp 3 1", ex_dst, ex_valid);
      end
   endtask

   task automatic test_load_use();
      ex_t e;
      instr_t add5;
      add5 = mk_add(5'd5, 5'd6, 5'd8);
      issue(mk_lw(5'd1, 5'd5), 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_ex() !== e) begin
         errors++; $display("FAIL lu_lw got %h exp %h", got_ex(), e);
      end
      issue(add5, 1'b0);
      e = sb.pop_front();
      checks++;
      if ((seen_stall !== exp_stall) || (exp_stall !== 1'b1)) begin
         errors++; $display("FAIL lu_stall got %b exp 1", seen_stall);
      end
      checks++;
      if (got_ex() !== e) begin
         errors++; $display("FAIL lu_bubble got %h exp %h", got_ex(), e);
      end
      issue(add5, 1'b0);
      e = sb.pop_front();
      checks++;
      if ((seen_stall !== 1'b0) || (got_ex() !== e)) begin
         errors++; $display("FAIL lu_release got stall=%b ex=%h exp 0 %h", seen_stall, got_ex(), e);
      end
      checks++;
      if ((stall_cnt !== m_sc) || (stall_cnt !== CNT_W'(1))) begin
         errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt);
      end
   endtask

   task automatic test_no_stall();
      ex_t e;
      issue(mk_lw(5'd2, 5'd5), 1'b0);
      void'(sb.pop_front());
      issue(mk_addi(5'd1, 5'd5), 1'b0);
      e = sb.pop_front();
      checks++;
      if ((seen_stall !== 1'b0) || (got_ex() !== e)) begin
         errors++; $display("FAIL addi_rt got stall=%b ex=%h exp 0 %h", seen_stall, got_ex(), e);
      end
      issue(mk_lw(5'd2, 5'd0), 1'b0);
      void'(sb.pop_front());
      issue(mk_add(5'd0, 5'd0, 5'd4), 1'b0);
      e = sb.pop_front();
      checks++;
      if ((seen_stall !== 1'b0) || (got_ex() !== e) || (ex_valid !== 1'b1)) begin
         errors++; $display("FAIL r0_use got stall=%b ex=%h exp 0 %h", seen_stall, got_ex(), e);
      end
   endtask

   task automatic test_flush();
      ex_t e;
      logic [CNT_W-1:0] sc0, fc0;
      issue(mk_lw(5'd1, 5'd5), 1'b0);
      void'(sb.pop_front());
      sc0 = stall_cnt; fc0 = flush_cnt;
      issue(mk_add(5'd5, 5'd1, 5'd2), 1'b1);
      e = sb.pop_front();
      checks++;
      if (seen_stall !== 1'b0) begin
         errors++; $display("FAIL flush_stall got %b exp 0", seen_stall);
      end
      checks++;
      if ((got_ex() !== e) || (ex_valid !== 1'b0)) begin
         errors++; $display("FAIL flush_bubble got %h exp %h", got_ex(), e);
      end
      checks++;
      if ((flush_cnt !== fc0 + CNT_W'(1)) || (stall_cnt !== sc0) ||
          (flush_cnt !== m_fc) || (stall_cnt !== m_sc)) begin
         errors++; $display("FAIL flush_cnts got fc=%0d sc=%0d exp fc=%0d sc=%0d",
                            flush_cnt, stall_cnt, m_fc, m_sc);
      end
   endtask

   task automatic test_invalid();
      ex_t e;
      instr_t i;
      i = mk_add(5'd9, 5'd10, 5'd11);
      i.valid = 0;
      issue(i, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_ex() !== e) begin
         errors++; $display("FAIL invalid_bubble got %h exp %h", got_ex(), e);
      end
      // A flush of an empty slot is not counted
      issue(i, 1'b1);
      e = sb.pop_front();
      checks++;
      if ((got_ex() !== e) || (flush_cnt !== m_fc)) begin
         errors++; $display("FAIL invalid_flush got ex=%h fc=%0d exp %h %0d", got_ex(), flush_cnt, e, m_fc);
      end
   endtask

   task automatic test_saturate();
      ex_t e;
      int bad = 0;
      for (int n = 0; n < 260; n++) begin
         issue(mk_lw(5'd1, 5'd7), 1'b0);
         e = sb.pop_front();
         if (got_ex() !== e) bad++;
         issue(mk_add(5'd7, 5'd3, 5'd4), 1'b0);
         e = sb.pop_front();
         if ((got_ex() !== e) || (seen_stall !== 1'b1)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL sat_seq got %0d bad cycles exp 0", bad);
      end
      checks++;
      if ((stall_cnt !== {CNT_W{1'b1}}) || (stall_cnt !== m_sc)) begin
         errors++; $display("FAIL sat_cnt got %h exp %h", stall_cnt, {CNT_W{1'b1}});
      end
   endtask

   task automatic test_reset_mid();
      ex_t e;
      issue(mk_lw(5'd1, 5'd5), 1'b0);
      e = sb.pop_front();
      checks++;
      if ((got_ex() !== e) || (ex_valid !== 1'b1)) begin
         errors++; $display("FAIL rm_pre got %h exp %h", got_ex(), e);
      end
      @(negedge clk);
      id_valid = 1; id_alusrc = 0; id_regdst = 1; id_memread = 0; id_memtoreg = 0;
      id_rs = 5'd5; id_rt = 5'd1; id_rd = 5'd2;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL rm_pending got %b exp 1", stall);
      end
      #1 rst = 1;
      #1;
      checks++;
      if ((got_ex() !== ex_t'(0)) || (stall !== 1'b0) || (stall_cnt !== '0) || (flush_cnt !== '0)) begin
         errors++; $display("FAIL rm_async got ex=%h stall=%b sc=%h fc=%h exp 0", got_ex(), stall, stall_cnt, flush_cnt);
      end
      @(posedge clk); #1;
      checks++;
      if (got_ex() !== ex_t'(0)) begin
         errors++; $display("FAIL rm_hold got %h exp 0", got_ex());
      end
      @(negedge clk);
      rst = 0;
      m_ex = '0; m_sc = '0; m_fc = '0;
      issue(mk_add(5'd12, 5'd13, 5'd14), 1'b0);
      e = sb.pop_front();
      checks++;
      if ((got_ex() !== e) || (seen_stall !== 1'b0) || (stall_cnt !== m_sc)) begin
         errors++; $display("FAIL rm_after got %h stall=%b sc=%0d exp %h 0 0", got_ex(), seen_stall, stall_cnt, e);
      end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_add();
      test_load_use();
      test_no_stall();
      test_flush();
      test_invalid();
      test_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and immediate width.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter CNT_W, default 16, event-counter width.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset. The ports SHALL be named clk and rst.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_wen, id_alusrc, id_regdst, id_branch, id_memwrite, id_memread, id_memtoreg  in  1 each  control-unit outputs.
- id_aluop  in  3  ALU operation.
- id_rdata1, id_rdata2, id_imm  in  DATA_W each  register operands and sign-extended immediate.
- id_rs, id_rt, id_rd  in  RA_W each  source and destination fields.
- flush  in  1  branch taken; squash the decode slot.
- ex_valid, ex_wen, ex_alusrc, ex_branch, ex_memwrite, ex_memread, ex_memtoreg  out  1 each  registered controls.
- ex_aluop  out  3  registered ALU operation.
- ex_rdata1, ex_rdata2, ex_imm  out  DATA_W each  registered operands.
- ex_rs, ex_rt  out  RA_W each  registered sources, used for forwarding.
- ex_dst  out  RA_W  resolved write register.
- stall  out  1  combinational; holds the PC and the IF/ID register.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-006 ex_dst SHALL be registered as id_rd when id_regdst=1, and as id_rt otherwise.
REQ-007 uses_rt SHALL be true when id_alusrc=0, id_memwrite=1, or id_branch=1.
REQ-008 Load-use hazard condition (combinational, all terms required):
- ex_valid=1 and ex_memread=1;
- ex_dst != 0;
- ex_dst == id_rs, or (ex_dst == id_rt and uses_rt);
- id_valid=1.
REQ-009 stall SHALL equal hazard AND NOT flush.
REQ-010 The stage SHALL capture one of three values at each rising edge, chosen by priority:
- flush=1: load a bubble.
- else hazard=1: load a bubble.
- else: load all id_* values.
REQ-011 A bubble SHALL set ex_valid and every control output to 0. ex_aluop, the operands, and the register fields SHALL also be 0.
REQ-012 The stage SHALL capture on every edge with no enable, so latency is exactly one cycle.
REQ-013 If id_valid=0 and there is no flush or hazard, the stage SHALL load a bubble.
REQ-014 A load-use stall SHALL last exactly one cycle, because the inserted bubble clears the hazard. Back-to-back hazards SHALL therefore never occur for a single instruction.
REQ-015 stall_cnt SHALL increment on each edge where stall=1. flush_cnt SHALL increment on each edge where flush=1 and id_valid=1. Both SHALL saturate at all-ones.
REQ-016 When flush and hazard occur together, the flush SHALL win: stall=0, a bubble is loaded, and only flush_cnt increments.

Reset
REQ-017 Asserting rst SHALL immediately set every registered output and both counters to 0, regardless of clk.
REQ-018 A bubble is held while rst=1, so stall=0.
REQ-019 The first capture SHALL occur on the first rising clk edge after rst deasserts.
REQ-020 Asserting rst while a stall is pending SHALL abort the stall. The held instruction is not captured.

Verification
REQ-021 ADD r3=r1+r2 (rd=3, regdst=1) -> one cycle later ex_valid=1, ex_dst=3, ex_aluop=id_aluop, stall=0.
REQ-022 LW r5 (rt=5), then ADD using rs=5 -> stall=1 for one cycle, then the bubble appears in EX. ADD enters EX the next cycle. stall_cnt=1.
REQ-023 LW r5, then ADDI with rt=5 (alusrc=1, so rt is not a source) -> no stall. LW writing r0, then any use of r0 -> no stall.
REQ-024 LW r5 followed by a dependent ADD, with flush=1 in the hazard cycle -> stall=0, bubble loaded, flush_cnt=1, stall_cnt=0.
REQ-025 stall_cnt preset to 0xFFFF via repeated hazards, then one more hazard -> stall_cnt remains 0xFFFF.
REQ-026 rst asserted mid-cycle with ex_valid=1 -> all outputs are 0 before the next clk edge. The first instruction after release is captured normally.
